fifo_burst_packer: RTL and testbench

//  Read-side consumer of the capture async FIFO, in the FIFO read clock domain.

---
 rtl/fifo_burst_packer_if.sv | 26 ++
 rtl/fifo_burst_packer.sv | 165 ++++++++++++++++
 tb/tb_fifo_burst_packer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_packer_if.sv
// FIFO read port plus packed-word output stream of the burst packer.
//   master : packer side (drives fifo_dequeue and the output stream)
//   slave  : environment side (FIFO read port and downstream sink)
interface fifo_burst_packer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
);
  logic                    fifo_empty;
  logic                    fifo_filled;
  logic                    fifo_dequeue;
  logic [WIDTH-1:0]        fifo_rdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH*PACK-1:0]   out_data;
  logic                    out_last;

  modport master (
    input  fifo_empty, fifo_filled, fifo_rdata, out_ready,
    output fifo_dequeue, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_filled, fifo_rdata, out_ready,
    input  fifo_dequeue, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_burst_packer.sv
// Read-side consumer of the capture async FIFO. Dequeues entries, packs PACK
// entries per output word (first entry in the low lane) and emits bursts of
// BURST_LEN words on a valid/ready stream, tagging the last word of a burst.
// A flush drains a partial frame tail as one short, zero-padded burst.
// Ports:
//   clk, rst_n  FIFO read clock, async active-low reset
//   flush       level request to drain the FIFO as a short burst
//   busy        FSM not idle or output queue holding a word
//   bus         FIFO read port + output stream (master side)
module fifo_burst_packer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PACK      = 4,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                busy,
  fifo_burst_packer_if.master bus
);

  localparam int unsigned OUT_W  = WIDTH * PACK;
  localparam int unsigned TOTAL  = BURST_LEN * PACK;
  localparam int unsigned ICNT_W = $clog2(TOTAL + 1);
  localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned WCNT_W = $clog2(BURST_LEN);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH, DRAIN} state_t;

  state_t                       state;
  logic [ICNT_W-1:0]            issue_cnt;   // entries issued in this burst
  logic [LANE_W-1:0]            issue_lane;  // lane of the next entry to issue
  logic [LANE_W-1:0]            lane_cnt;    // lane of the next entry to capture
  logic [WCNT_W-1:0]            word_cnt;    // words pushed in this burst
  logic [1:0]                   resv;        // output slots reserved (queued + assembling)
  logic                         in_flight;   // a dequeued entry lands this cycle
  logic [PACK-1:0][WIDTH-1:0]   asm_q;       // word under assembly
  logic                         skid_valid;
  logic                         skid_last;
  logic [OUT_W-1:0]             skid_data;

  logic                         entries_left;
  logic                         slot_ok;
  logic                         issuing;
  logic                         lane_full;
  logic                         flush_done;
  logic                         pop;
  logic                         push;
  logic                         push_last;
  logic [PACK-1:0][WIDTH-1:0]   asm_next;
  logic [OUT_W-1:0]             push_data;

  // Issue, capture and push decisions
  always_comb begin
    entries_left = issue_cnt < ICNT_W'(TOTAL);
    // Only a new word needs a free slot; its later lanes ride on that reservation.
    slot_ok      = (issue_lane != '0) || (resv < 2'd2);
    issuing      = ((state == BURST) || (state == FLUSH)) && !bus.fifo_empty &&
                   entries_left && slot_ok;
    lane_full    = in_flight && (lane_cnt == LANE_W'(PACK - 1));
    flush_done   = (state == FLUSH) && bus.fifo_empty && !in_flight;
    pop          = bus.out_valid && bus.out_ready;
    asm_next     = asm_q;
    if (in_flight) asm_next[lane_cnt] = bus.fifo_rdata;
    // Unfilled lanes are already zero because asm_q clears on every push.
    push         = lane_full || (flush_done && (lane_cnt != '0));
    push_data    = asm_next;
    // In FLUSH an empty FIFO with nothing further issuable marks the final word.
    push_last    = (word_cnt == WCNT_W'(BURST_LEN - 1)) ||
                   ((state == FLUSH) && bus.fifo_empty);
  end

  assign bus.fifo_dequeue = issuing;
  assign busy             = (state != IDLE) || bus.out_valid;

  // FSM, packing datapath and 2-entry output queue (head drives the outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      issue_cnt     <= '0;
      issue_lane    <= '0;
      lane_cnt      <= '0;
      word_cnt      <= '0;
      resv          <= '0;
      in_flight     <= 1'b0;
      asm_q         <= '0;
      skid_valid    <= 1'b0;
      skid_last     <= 1'b0;
      skid_data     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      in_flight <= issuing;

      if (issuing) begin
        issue_cnt  <= issue_cnt + 1'b1;
        issue_lane <= (issue_lane == LANE_W'(PACK - 1)) ? '0 : issue_lane + 1'b1;
      end

      case ({issuing && (issue_lane == '0), pop})
        2'b10:   resv <= resv + 2'd1;
        2'b01:   resv <= resv - 2'd1;
        default: ;
      endcase

      if (in_flight)
        lane_cnt <= (lane_cnt == LANE_W'(PACK - 1)) ? '0 : lane_cnt + 1'b1;
      else if (flush_done)
        lane_cnt <= '0;

      asm_q <= push ? '0 : asm_next;

      if (push) word_cnt <= push_last ? '0 : word_cnt + 1'b1;

      if (pop) begin
        if (skid_valid) begin
          bus.out_data <= skid_data;
          bus.out_last <= skid_last;
          if (push) begin
            skid_data <= push_data;
            skid_last <= push_last;
          end else begin
            skid_valid <= 1'b0;
          end
        end else if (push) begin
          bus.out_data <= push_data;
          bus.out_last <= push_last;
        end else begin
          bus.out_valid <= 1'b0;
          bus.out_last  <= 1'b0;
        end
      end else if (push) begin
        if (!bus.out_valid) begin
          bus.out_valid <= 1'b1;
          bus.out_data  <= push_data;
          bus.out_last  <= push_last;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= push_data;
          skid_last  <= push_last;
        end
      end

      case (state)
        IDLE: begin
          issue_cnt  <= '0;
          issue_lane <= '0;
          word_cnt   <= '0;
          if (bus.fifo_filled)                  state <= BURST;
          else if (flush && !bus.fifo_empty)    state <= FLUSH;
        end
        BURST, FLUSH: begin
          if (issuing && (issue_cnt == ICNT_W'(TOTAL - 1))) state <= DRAIN;
          else if (flush_done)                              state <= DRAIN;
        end
        DRAIN: begin
          if (!in_flight && (lane_cnt == '0)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed bench for fifo_burst_packer: table of FIFO preload scenarios with
// hand-computed expected words, plus mid-burst underrun and mid-burst reset.
module tb_fifo_burst_packer;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  fifo_burst_packer_if #(.WIDTH(8), .PACK(4)) bus();

  fifo_burst_packer #(.WIDTH(8), .PACK(4), .BURST_LEN(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered empty that reflects a same-cycle dequeue
  logic [7:0] fq[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      bus.fifo_empty <= 1'b1;
      bus.fifo_rdata <= '0;
    end else begin
      if (bus.fifo_dequeue && fq.size() != 0) bus.fifo_rdata <= fq.pop_front();
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor state
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          cyc;
  int          rdy_per;
  int          acc;
  int          deq_total, deq_a, deq_b;
  int          v_deq_empty, v_held, v_stable;
  bit          chk_held;
  bit          busy_seen;
  bit          stalled_prev;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic reset_mon(int per, bit held_en);
    got_data.delete(); got_last.delete(); got_cyc.delete();
    rdy_per = per; chk_held = held_en;
    acc = 0; deq_total = 0; deq_a = 0; deq_b = 0;
    v_deq_empty = 0; v_held = 0; v_stable = 0;
    busy_seen = 1'b0; stalled_prev = 1'b0;
  endtask

  // One clock: drive ready, then sample everything mid-cycle
  task automatic cycle();
    int held;
    @(negedge clk);
    cyc++;
    bus.out_ready = (rdy_per <= 1) ? 1'b1 : ((cyc % rdy_per) == 0);
    if (busy) busy_seen = 1'b1;
    if (bus.fifo_dequeue && bus.fifo_empty) v_deq_empty++;
    held = deq_a / 4 - acc;
    if (chk_held && held >= 2 && bus.fifo_dequeue) v_held++;
    if (stalled_prev &&
        (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
      v_stable++;
    if (bus.out_valid && bus.out_ready) begin
      got_data.push_back(bus.out_data);
      got_last.push_back(bus.out_last);
      got_cyc.push_back(cyc);
      acc++;
    end
    stalled_prev = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_last = bus.out_last;
    deq_a = deq_b;
    if (bus.fifo_dequeue) begin
      deq_b++;
      deq_total++;
    end
  endtask

  function automatic int bad_words(int n, logic [7:0] base);
    int bad;
    logic [31:0] e;
    bad = 0;
    for (int i = 0; i < got_data.size(); i++) begin
      e = '0;
      for (int j = 0; j < 4; j++)
        if (i * 4 + j < n) e[j*8 +: 8] = 8'(base + i * 4 + j);
      if (got_data[i] !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int last_count();
    int c;
    c = 0;
    foreach (got_last[i]) if (got_last[i]) c++;
    return c;
  endfunction

  task automatic preload(int n, logic [7:0] base);
    for (int i = 0; i < n; i++) fq.push_back(8'(base + i));
  endtask

  typedef struct {
    int          n_ent;
    logic [7:0]  base;
    bit          use_flush;
    int          rdy_per;
    int          exp_words;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.fifo_filled = 1'b0;
    bus.out_ready = 1'b0;
    cyc = 0;
    reset_mon(1, 1'b0);

    vecs[0] = '{64, 8'h00, 1'b0, 1, 16, 32'h03020100, 32'h3F3E3D3C};
    vecs[1] = '{64, 8'h00, 1'b0, 4, 16, 32'h03020100, 32'h3F3E3D3C};
    vecs[2] = '{6,  8'hA0, 1'b1, 1, 2,  32'hA3A2A1A0, 32'h0000A5A4};
    vecs[3] = '{0,  8'h00, 1'b1, 1, 0,  32'h0,        32'h0};
    vecs[4] = '{9,  8'h40, 1'b1, 2, 3,  32'h43424140, 32'h00000048};

    repeat (3) @(negedge clk);
    chk("rst_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_last",    64'(bus.out_last), 64'd0);
    chk("rst_data",    64'(bus.out_data), 64'd0);
    chk("rst_dequeue", 64'(bus.fifo_dequeue), 64'd0);
    chk("rst_busy",    64'(busy), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Table-driven scenarios
    foreach (vecs[v]) begin
      reset_mon(vecs[v].rdy_per, !vecs[v].use_flush);
      preload(vecs[v].n_ent, vecs[v].base);
      if (vecs[v].use_flush) flush = 1'b1;
      else bus.fifo_filled = 1'b1;
      for (int k = 0; k < 300; k++) begin
        cycle();
        if (k == 3) begin
          flush = 1'b0;
          bus.fifo_filled = 1'b0;
        end
      end
      chk($sformatf("v%0d_words", v), 64'(got_data.size()), 64'(vecs[v].exp_words));
      chk($sformatf("v%0d_deq_cnt", v), 64'(deq_total), 64'(vecs[v].n_ent));
      chk($sformatf("v%0d_deq_empty", v), 64'(v_deq_empty), 64'd0);
      chk($sformatf("v%0d_stable", v), 64'(v_stable), 64'd0);
      chk($sformatf("v%0d_held2", v), 64'(v_held), 64'd0);
      chk($sformatf("v%0d_busy_end", v), 64'(busy), 64'd0);
      chk($sformatf("v%0d_busy_seen", v), 64'(busy_seen), 64'(vecs[v].exp_words > 0));
      if (got_data.size() != 0) begin
        n = got_data.size();
        chk($sformatf("v%0d_first", v), 64'(got_data[0]), 64'(vecs[v].exp_first));
        chk($sformatf("v%0d_final", v), 64'(got_data[n-1]), 64'(vecs[v].exp_final));
        chk($sformatf("v%0d_final_last", v), 64'(got_last[n-1]), 64'd1);
        chk($sformatf("v%0d_last_cnt", v), 64'(last_count()), 64'd1);
        chk($sformatf("v%0d_pattern", v), 64'(bad_words(vecs[v].n_ent, vecs[v].base)), 64'd0);
        if (vecs[v].rdy_per == 1 && !vecs[v].use_flush)
          chk($sformatf("v%0d_spacing", v), 64'(got_cyc[n-1] - got_cyc[0]), 64'd60);
      end
    end

    // FIFO runs dry after 10 entries mid-burst, refilled 50+ cycles later
    reset_mon(1, 1'b1);
    preload(10, 8'h00);
    bus.fifo_filled = 1'b1;
    for (int k = 0; k < 60; k++) begin
      cycle();
      if (k == 3) bus.fifo_filled = 1'b0;
    end
    chk("gap_words", 64'(got_data.size()), 64'd2);
    chk("gap_deq_cnt", 64'(deq_total), 64'd10);
    chk("gap_busy", 64'(busy), 64'd1);
    preload(54, 8'h0A);
    repeat (300) cycle();
    chk("gap_total_words", 64'(got_data.size()), 64'd16);
    chk("gap_deq_empty", 64'(v_deq_empty), 64'd0);
    chk("gap_pattern", 64'(bad_words(64, 8'h00)), 64'd0);
    chk("gap_last_cnt", 64'(last_count()), 64'd1);
    if (got_data.size() == 16) begin
      chk("gap_word2", 64'(got_data[2]), 64'h0B0A0908);
      chk("gap_final_last", 64'(got_last[15]), 64'd1);
    end
    chk("gap_busy_end", 64'(busy), 64'd0);

    // Reset pulsed mid-burst, then a clean burst afterwards
    reset_mon(1, 1'b1);
    preload(64, 8'h00);
    bus.fifo_filled = 1'b1;
    for (int k = 0; k < 200 && acc < 7; k++) begin
      cycle();
      if (k == 3) bus.fifo_filled = 1'b0;
    end
    bus.fifo_filled = 1'b0;
    chk("rst_mid_reach", 64'(acc), 64'd7);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",   64'(bus.out_valid), 64'd0);
    chk("rst_mid_dequeue", 64'(bus.fifo_dequeue), 64'd0);
    chk("rst_mid_busy",    64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle();
    reset_mon(1, 1'b1);
    preload(64, 8'h80);
    bus.fifo_filled = 1'b1;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (k == 3) bus.fifo_filled = 1'b0;
    end
    chk("post_rst_words", 64'(got_data.size()), 64'd16);
    chk("post_rst_pattern", 64'(bad_words(64, 8'h80)), 64'd0);
    if (got_data.size() == 16) begin
      chk("post_rst_first", 64'(got_data[0]), 64'h83828180);
      chk("post_rst_final", 64'(got_data[15]), 64'hBFBEBDBC);
      chk("post_rst_last", 64'(got_last[15]), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
